sseg_scan_ctrl: RTL and testbench



---
 rtl/sseg_scan_ctrl_pkg.sv | 15 +
 rtl/sseg_scan_ctrl_prescaler.sv | 34 +++
 rtl/sseg_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared display types: the BCD digit handed to BCD_to_sseg and the scan FSM states.
package packs;

  typedef struct packed {
    logic       dp;
    logic [3:0] digito;
  } BCDnumber_t;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } sseg_scan_state_t;

endpackage

// File: rtl/sseg_scan_ctrl_prescaler.sv
// Slot prescaler: free-running 0..SCAN_DIV-1 counter with blank/slot boundary strobes.
// Latency: strobes are decoded from the count register, no extra delay.
// Backpressure: none; clr holds the count at zero.
module scan_prescaler #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic blank_end,
  output logic slot_end,
  output logic pre_slot_end
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;

  assign blank_end    = (cnt == CW'(BLANK_CYCLES - 1));
  assign slot_end     = (cnt == CW'(SCAN_DIV - 1));
  assign pre_slot_end = (cnt == CW'(SCAN_DIV - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Seven-segment scan controller: shadowed BCD digits, per-slot blanking, leading-zero suppression.
// Latency: all outputs registered; hex_out/digit_idx settle BLANK_CYCLES before an asserts.
// Backpressure: none; loads are held pending and committed at the frame boundary.
module sseg_scan_ctrl
  import packs::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int SCAN_DIV      = 100000,
  parameter int BLANK_CYCLES  = 8,
  parameter bit AN_ACTIVE_LOW = 1'b1,
  localparam int IW           = $clog2(N_DIGITS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        load,
  input  BCDnumber_t [N_DIGITS-1:0]   digits_in,
  input  logic                        lz_blank,
  output BCDnumber_t                  hex_out,
  output logic [N_DIGITS-1:0]         an,
  output logic [IW-1:0]               digit_idx,
  output logic                        frame_done
);

  localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_ACTIVE_LOW}};

  sseg_scan_state_t          state_q, state_d;
  logic [IW-1:0]             idx_d;
  BCDnumber_t [N_DIGITS-1:0] shadow_q, shadow_d, pend_q;
  logic                      pending_q, pending_d;
  logic                      commit, next_slot, chain;
  logic [N_DIGITS-1:0]       lzb, oh;
  logic [N_DIGITS-1:0]       an_d;
  BCDnumber_t                hex_d;
  logic                      frame_done_d;
  logic                      clr, blank_end, slot_end, pre_slot_end;

  assign clr = !en || (state_q == IDLE);

  scan_prescaler #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .blank_end    (blank_end),
    .slot_end     (slot_end),
    .pre_slot_end (pre_slot_end)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = digit_idx;
    case (state_q)
      IDLE: begin
        state_d = BLANK;
        idx_d   = '0;
      end
      BLANK: if (blank_end) state_d = SHOW;
      SHOW: begin
        if (slot_end) begin
          state_d = BLANK;
          idx_d   = (digit_idx == IW'(N_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
    end
  end

  // Shadow only moves between frames (or while idle) so a frame never mixes old and new digits.
  always_comb begin
    commit    = frame_done || (state_q == IDLE);
    shadow_d  = shadow_q;
    pending_d = pending_q || load;
    if (commit && load) begin
      shadow_d  = digits_in;
      pending_d = 1'b0;
    end else if (commit && pending_q) begin
      shadow_d  = pend_q;
      pending_d = 1'b0;
    end
  end

  // A digit is suppressed only if it and every higher digit are plain zeros.
  always_comb begin
    lzb   = '0;
    chain = lz_blank;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      chain  = chain && (shadow_q[i].digito == 4'd0) && !shadow_q[i].dp;
      lzb[i] = chain;
    end
  end

  always_comb begin
    next_slot    = en && ((state_q == IDLE) || ((state_q == SHOW) && slot_end));
    hex_d        = next_slot ? shadow_d[idx_d] : hex_out;
    oh           = '0;
    oh[idx_d]    = 1'b1;
    an_d         = AN_OFF;
    if (state_d == SHOW) begin
      if (state_q == SHOW) an_d = an;
      else                 an_d = lzb[idx_d] ? AN_OFF : (oh ^ AN_OFF);
    end
    frame_done_d = en && (state_q != IDLE) && pre_slot_end
                   && (digit_idx == IW'(N_DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      digit_idx  <= '0;
      shadow_q   <= '0;
      pend_q     <= '0;
      pending_q  <= 1'b0;
      hex_out    <= '0;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_idx  <= idx_d;
      shadow_q   <= shadow_d;
      if (load) pend_q <= digits_in;
      pending_q  <= pending_d;
      hex_out    <= hex_d;
      an         <= an_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with N_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, active-low enables.
module tb_sseg_scan_ctrl;
  import packs::*;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;

  typedef BCDnumber_t [ND-1:0] digs_t;

  logic       clk = 1'b0;
  logic       rst_n, en, load, lz_blank;
  digs_t      digits_in;
  BCDnumber_t hex_out;
  logic [3:0] an;
  logic [1:0] digit_idx;
  logic       frame_done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(
    .N_DIGITS      (ND),
    .SCAN_DIV      (SD),
    .BLANK_CYCLES  (BC),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .digits_in  (digits_in),
    .lz_blank   (lz_blank),
    .hex_out    (hex_out),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  function automatic digs_t mk(input logic [15:0] d);
    digs_t r;
    for (int i = 0; i < ND; i++) begin
      r[i].digito = d[i*4 +: 4];
      r[i].dp     = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Entered on the first BLANK cycle of slot 0; leaves on the first cycle of the following frame.
  task automatic check_frame(input int f, input logic [15:0] exp_d, input logic [3:0] mask,
                             input int load_at, input logic [15:0] load_d);
    logic [3:0] prev_hex;
    logic       prev_act;
    logic [3:0] exp_an;
    int         s, c;
    prev_act = 1'b0;
    prev_hex = 4'd0;
    for (int k = 0; k < ND*SD; k++) begin
      s      = k / SD;
      c      = k % SD;
      exp_an = (c >= BC && !mask[s]) ? ~(4'b0001 << s) : 4'b1111;
      chk($sformatf("an f%0d k%0d", f, k), an, exp_an);
      chk($sformatf("idx f%0d k%0d", f, k), digit_idx, s);
      chk($sformatf("hex f%0d k%0d", f, k), hex_out.digito, exp_d[s*4 +: 4]);
      chk($sformatf("frame_done f%0d k%0d", f, k), frame_done, (k == ND*SD - 1));
      if (an != 4'b1111) begin
        chk($sformatf("onehot f%0d k%0d", f, k), $countones(~an), 1);
        if (prev_act) chk($sformatf("stable f%0d k%0d", f, k), hex_out.digito, prev_hex);
      end
      prev_act = (an != 4'b1111);
      prev_hex = hex_out.digito;
      load     = (k == load_at);
      if (k == load_at) digits_in = mk(load_d);
      step(1);
    end
    load = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    load      = 1'b0;
    lz_blank  = 1'b0;
    digits_in = '0;
    step(2);
    chk("rst an", an, 4'b1111);
    chk("rst hex", hex_out, 0);
    chk("rst idx", digit_idx, 0);
    chk("rst frame_done", frame_done, 0);

    rst_n = 1'b1;
    step(1);
    chk("idle an", an, 4'b1111);

    // Load in IDLE together with enable, then plain scanning.
    en        = 1'b1;
    load      = 1'b1;
    digits_in = mk(16'h3210);
    step(1);
    load = 1'b0;
    check_frame(1, 16'h3210, 4'b0000, -1, 16'h0000);

    // Mid-frame load waits for the boundary; a load on the frame_done cycle lands directly.
    check_frame(2, 16'h3210, 4'b0000, 10, 16'h9999);
    check_frame(3, 16'h9999, 4'b0000, ND*SD - 1, 16'h5678);
    lz_blank = 1'b1;
    check_frame(4, 16'h5678, 4'b0000, ND*SD - 1, 16'h0040);

    // Leading-zero blanking.
    check_frame(5, 16'h0040, 4'b1100, ND*SD - 1, 16'h0000);
    check_frame(6, 16'h0000, 4'b1110, -1, 16'h0000);

    // Drop enable during SHOW of slot 2.
    lz_blank = 1'b0;
    step(19);
    chk("slot2 show an", an, 4'b1011);
    chk("slot2 show idx", digit_idx, 2);
    en = 1'b0;
    step(1);
    chk("disable an", an, 4'b1111);
    chk("disable idx", digit_idx, 0);
    chk("disable frame_done", frame_done, 0);
    step(3);
    chk("idle hold an", an, 4'b1111);
    chk("idle hold idx", digit_idx, 0);

    load      = 1'b1;
    digits_in = mk(16'h1234);
    step(1);
    load = 1'b0;
    en   = 1'b1;
    step(1);
    check_frame(7, 16'h1234, 4'b0000, -1, 16'h0000);

    // Asynchronous reset during SHOW of slot 3.
    step(27);
    chk("slot3 show an", an, 4'b0111);
    chk("slot3 show idx", digit_idx, 3);
    chk("slot3 show hex", hex_out.digito, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst an", an, 4'b1111);
    chk("async rst hex", hex_out, 0);
    chk("async rst idx", digit_idx, 0);
    chk("async rst frame_done", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check_frame(8, 16'h0000, 4'b0000, -1, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
